// File: rtl/counter_bank.sv
// Bank of NCH up/down counters with sticky terminal-count flags.
// Live counts are only observable through an atomically captured shadow bank.
module counter_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int SAT   = 0
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   trig_reset,
    input  logic [NCH-1:0]   trig_load,
    input  logic [NCH-1:0]   trig_up,
    input  logic [NCH-1:0]   trig_down,
    input  logic [NCH-1:0]   run_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             snap,
    input  logic             clr_flags,
    input  logic [2:0]       rd_ch,
    input  logic [1:0]       rd_word,
    output logic [15:0]      rd_data,
    output logic             snap_done,
    output logic [NCH-1:0]   tc
);

    localparam int               NWORD    = WIDTH / 16;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count  [NCH];
    logic [WIDTH-1:0] r_shadow [NCH];
    logic [NCH-1:0]   r_tc;
    logic [15:0]      r_rd_data;
    logic             r_snap_done;

    logic [WIDTH-1:0] w_count_nxt [NCH];
    logic [NCH-1:0]   w_inc;
    logic [NCH-1:0]   w_dec;
    logic [NCH-1:0]   w_tc_set;
    logic [NCH-1:0]   w_tc_nxt;
    logic [15:0]      w_words [8][4];

    assign w_inc = trig_up | run_en;
    assign w_dec = trig_down;

    // Per-channel next count and flag: reset > load > inc/dec, overflow raises the flag.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_count_nxt[i] = r_count[i];
            w_tc_set[i]    = 1'b0;
            w_tc_nxt[i]    = r_tc[i];
            if (trig_reset[i]) begin
                w_count_nxt[i] = ZERO;
            end else if (trig_load[i]) begin
                w_count_nxt[i] = load_value;
            end else if (w_inc[i] && !w_dec[i]) begin
                if (r_count[i] == ALL_ONES) begin
                    w_tc_set[i]    = 1'b1;
                    w_count_nxt[i] = (SAT != 0) ? ALL_ONES : ZERO;
                end else begin
                    w_count_nxt[i] = r_count[i] + ONE;
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_count[i] == ZERO) begin
                    w_tc_set[i]    = 1'b1;
                    w_count_nxt[i] = (SAT != 0) ? ZERO : ALL_ONES;
                end else begin
                    w_count_nxt[i] = r_count[i] - ONE;
                end
            end else begin
                w_count_nxt[i] = r_count[i];
            end

            if (trig_reset[i]) begin
                w_tc_nxt[i] = 1'b0;
            end else if (w_tc_set[i]) begin
                w_tc_nxt[i] = 1'b1;
            end else if (clr_flags) begin
                w_tc_nxt[i] = 1'b0;
            end else begin
                w_tc_nxt[i] = r_tc[i];
            end
        end
    end

    // Full 8x4 word map so out-of-range selects read as zero without partial indexing.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rd_ch
        for (genvar gj = 0; gj < 4; gj++) begin : g_rd_word
            if ((gi < NCH) && (gj < NWORD)) begin : g_live
                assign w_words[gi][gj] = r_shadow[gi][16*gj +: 16];
            end else begin : g_zero
                assign w_words[gi][gj] = 16'h0000;
            end
        end
    end

    // Counter and shadow state; shadows take the pre-update counts.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_count[i]  <= ZERO;
                r_shadow[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_count[i] <= w_count_nxt[i];
                if (snap) begin
                    r_shadow[i] <= r_count[i];
                end
            end
        end
    end

    // Registered flags and readback outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tc        <= {NCH{1'b0}};
            r_snap_done <= 1'b0;
            r_rd_data   <= 16'h0000;
        end else begin
            r_tc        <= w_tc_nxt;
            r_snap_done <= snap;
            r_rd_data   <= w_words[rd_ch][rd_word];
        end
    end

    assign rd_data   = r_rd_data;
    assign snap_done = r_snap_done;
    assign tc        = r_tc;

endmodule

// File: tb/tb_counter_bank.sv
// Drives a wrapping and a saturating counter_bank with shared stimulus; a
// reference model pushes expected outputs that a monitor pops each cycle.
module tb_counter_bank;

    localparam int          NCH   = 4;
    localparam int          WIDTH = 32;
    localparam int          NW    = WIDTH / 16;
    localparam longint      MAXL  = 64'h0000_0000_FFFF_FFFF;

    logic             sys_clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [NCH-1:0]   trig_reset = '0, trig_load = '0, trig_up = '0, trig_down = '0, run_en = '0;
    logic [WIDTH-1:0] load_value = '0;
    logic             snap = 1'b0, clr_flags = 1'b0;
    logic [2:0]       rd_ch = '0;
    logic [1:0]       rd_word = '0;
    logic [15:0]      rd_data0, rd_data1;
    logic             snap_done0, snap_done1;
    logic [NCH-1:0]   tc0, tc1;

    always #5 sys_clk = ~sys_clk;

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .SAT(0)) u_wrap (
        .sys_clk(sys_clk), .reset_n(reset_n), .trig_reset(trig_reset), .trig_load(trig_load),
        .trig_up(trig_up), .trig_down(trig_down), .run_en(run_en), .load_value(load_value),
        .snap(snap), .clr_flags(clr_flags), .rd_ch(rd_ch), .rd_word(rd_word),
        .rd_data(rd_data0), .snap_done(snap_done0), .tc(tc0));

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .SAT(1)) u_sat (
        .sys_clk(sys_clk), .reset_n(reset_n), .trig_reset(trig_reset), .trig_load(trig_load),
        .trig_up(trig_up), .trig_down(trig_down), .run_en(run_en), .load_value(load_value),
        .snap(snap), .clr_flags(clr_flags), .rd_ch(rd_ch), .rd_word(rd_word),
        .rd_data(rd_data1), .snap_done(snap_done1), .tc(tc1));

    typedef struct packed {
        logic [15:0]    rd0;
        logic [15:0]    rd1;
        logic           sd;
        logic [NCH-1:0] tc0;
        logic [NCH-1:0] tc1;
    } exp_t;

    exp_t   exp_q[$];
    longint m_cnt [2][NCH];
    longint m_shd [2][NCH];
    bit     m_tc  [2][NCH];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int s, input int ch, input int w);
        if (ch >= NCH || w >= NW) return 16'h0000;
        return 16'((m_shd[s][ch] >> (16 * w)) & 64'hFFFF);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[s][c] = 0;
                m_shd[s][c] = 0;
                m_tc[s][c]  = 1'b0;
            end
        end
    endtask

    // Apply the currently driven inputs to the model, clock once, queue the expectation.
    task automatic step();
        exp_t   e;
        longint v;
        bit     set;
        e.rd0 = exp_word(0, int'(rd_ch), int'(rd_word));
        e.rd1 = exp_word(1, int'(rd_ch), int'(rd_word));
        e.sd  = snap;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if (snap) m_shd[s][c] = m_cnt[s][c];
                set = 1'b0;
                if (trig_reset[c]) v = 0;
                else if (trig_load[c]) v = longint'(load_value);
                else begin
                    v = m_cnt[s][c] + ((trig_up[c] || run_en[c]) ? 1 : 0) - (trig_down[c] ? 1 : 0);
                    if (v > MAXL) begin
                        set = 1'b1;
                        v   = (s == 1) ? MAXL : v - (MAXL + 1);
                    end else if (v < 0) begin
                        set = 1'b1;
                        v   = (s == 1) ? 0 : v + (MAXL + 1);
                    end
                end
                m_cnt[s][c] = v;
                if (trig_reset[c]) m_tc[s][c] = 1'b0;
                else if (set) m_tc[s][c] = 1'b1;
                else if (clr_flags) m_tc[s][c] = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e.tc0[c] = m_tc[0][c];
            e.tc1[c] = m_tc[1][c];
        end
        @(posedge sys_clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        trig_reset = '0; trig_load = '0; trig_up = '0; trig_down = '0; run_en = '0;
        snap = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic snap_read(input string nm, input int ch, input logic [15:0] w0_wrap,
                             input logic [15:0] w1_wrap, input logic [15:0] w0_sat,
                             input logic [15:0] w1_sat);
        idle(); snap = 1'b1; rd_ch = 3'(ch); rd_word = 2'd0; step();
        chk({nm, "_snap_done"}, 64'(snap_done0), 64'd1);
        idle(); step();
        chk({nm, "_snap_done_clear"}, 64'(snap_done0), 64'd0);
        chk({nm, "_w0_wrap"}, 64'(rd_data0), 64'(w0_wrap));
        chk({nm, "_w0_sat"}, 64'(rd_data1), 64'(w0_sat));
        rd_word = 2'd1; step();
        chk({nm, "_w1_wrap"}, 64'(rd_data0), 64'(w1_wrap));
        chk({nm, "_w1_sat"}, 64'(rd_data1), 64'(w1_sat));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_rd0"}, 64'(rd_data0), 64'd0);
        chk({nm, "_rd1"}, 64'(rd_data1), 64'd0);
        chk({nm, "_sd0"}, 64'(snap_done0), 64'd0);
        chk({nm, "_sd1"}, 64'(snap_done1), 64'd0);
        chk({nm, "_tc0"}, 64'(tc0), 64'd0);
        chk({nm, "_tc1"}, 64'(tc1), 64'd0);
    endtask

    // Asynchronous reset mid-run; commands issued while low must leave no trace.
    task automatic mid_reset();
        exp_q.delete();
        idle();
        #2 reset_n = 1'b0;
        #1 check_all_zero("midrst");
        run_en = '1; trig_load = '1; load_value = 32'h1234_5678; snap = 1'b1;
        @(posedge sys_clk); #1;
        idle();
        @(posedge sys_clk); #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    function automatic logic [NCH-1:0] rmask(input int odds);
        logic [NCH-1:0] m;
        for (int i = 0; i < NCH; i++) m[i] = ($urandom_range(0, odds - 1) == 0);
        return m;
    endfunction

    // Scoreboard monitor: outputs are presented every cycle, sampled mid-period.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_rd_wrap", 64'(rd_data0), 64'(e.rd0));
                chk("sb_rd_sat", 64'(rd_data1), 64'(e.rd1));
                chk("sb_snap_done_wrap", 64'(snap_done0), 64'(e.sd));
                chk("sb_snap_done_sat", 64'(snap_done1), 64'(e.sd));
                chk("sb_tc_wrap", 64'(tc0), 64'(e.tc0));
                chk("sb_tc_sat", 64'(tc1), 64'(e.tc1));
            end
        end
    end

    initial begin
        logic [NCH-1:0] run_phase;
        model_clear();
        #1 reset_n = 1'b0;
        #2 check_all_zero("rst");
        @(posedge sys_clk); #1;
        reset_n = 1'b1;

        // Load then coherent two-word readback.
        idle(); trig_load[0] = 1'b1; load_value = 32'h0001_FFFF; step();
        snap_read("load", 0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001);

        // Overflow: wrap to zero vs hold at all-ones, flag in both.
        idle(); trig_load[1] = 1'b1; load_value = 32'hFFFF_FFFE; step();
        idle(); trig_up[1] = 1'b1; step(); step();
        chk("ovf_tc_wrap", 64'(tc0[1]), 64'd1);
        chk("ovf_tc_sat", 64'(tc1[1]), 64'd1);
        snap_read("ovf", 1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        idle(); clr_flags = 1'b1; step();
        chk("clr_tc_wrap", 64'(tc0[1]), 64'd0);

        // Underflow from zero on ch2, then overflow from all-ones.
        idle(); trig_reset[2] = 1'b1; step();
        idle(); trig_down[2] = 1'b1; step();
        chk("unf_tc_wrap", 64'(tc0[2]), 64'd1);
        chk("unf_tc_sat", 64'(tc1[2]), 64'd1);
        snap_read("unf", 2, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        idle(); trig_load[2] = 1'b1; load_value = 32'hFFFF_FFFF; step();
        idle(); trig_up[2] = 1'b1; clr_flags = 1'b1; step();
        chk("set_beats_clr", 64'(tc0[2]), 64'd1);
        snap_read("sat_hold", 2, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);

        // Priority, hold on up+down, and 100 cycles of free-run.
        idle(); trig_load[0] = 1'b1; load_value = 32'h0000_0050; step();
        idle(); trig_reset[0] = 1'b1; trig_load[0] = 1'b1; trig_up[0] = 1'b1; step();
        idle(); trig_up[0] = 1'b1; trig_down[0] = 1'b1; step();
        snap_read("prio", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        idle(); run_en[0] = 1'b1;
        for (int n = 0; n < 100; n++) step();
        snap_read("run100", 0, 16'h0064, 16'h0000, 16'h0064, 16'h0000);

        // Out-of-range channel reads as zero.
        idle(); rd_ch = 3'd5; rd_word = 2'd0; step(); step();
        chk("oob_ch_wrap", 64'(rd_data0), 64'd0);

        // Randomized traffic with a mid-run asynchronous reset.
        run_phase = '0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) run_phase = rmask(2);
            if (n == 700) mid_reset();
            trig_reset = rmask(24);
            trig_load  = rmask(12);
            trig_up    = rmask(3);
            trig_down  = rmask(3);
            run_en     = run_phase;
            case ($urandom_range(0, 4))
                0: load_value = 32'hFFFF_FFFF;
                1: load_value = 32'hFFFF_FFFE;
                2: load_value = 32'h0000_0000;
                3: load_value = 32'h0000_0001;
                default: load_value = $urandom;
            endcase
            snap      = ($urandom_range(0, 3) == 0);
            clr_flags = ($urandom_range(0, 7) == 0);
            rd_ch     = 3'($urandom_range(0, 7));
            rd_word   = 2'($urandom_range(0, 3));
            step();
        end

        idle();
        step();
        @(negedge sys_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
